// File: rtl/float_unpacker_pipe_if.sv
// Streaming bus of the float-to-fixed converter: float input side and fixed-point output side.
// master drives the input stream and consumes results; slave is the converter.
interface float_unpacker_pipe_if #(
   parameter int FRAC_WIDTH = 22
);
   logic                  in_valid;
   logic                  in_ready;
   logic [31:0]           in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [FRAC_WIDTH+1:0] out_result;
   logic [4:0]            out_flags;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_result, out_flags
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_result, out_flags
   );
endinterface

// File: rtl/float_unpacker_pipe.sv
// IEEE-754 single to signed fixed point (sign, one integer bit, FRAC_WIDTH fraction bits).
// Three stages (decode, align, round/saturate/negate) that all hold while the output is stalled.
module float_unpacker_pipe #(
   parameter int FRAC_WIDTH = 22,
   parameter int ROUND      = 0
) (
   input logic                  clk,
   input logic                  reset,
   float_unpacker_pipe_if.slave bus
);
   localparam int RW = FRAC_WIDTH + 2;
   localparam int MW = FRAC_WIDTH + 1;
   localparam logic [RW-1:0] ONE = {2'b01, {FRAC_WIDTH{1'b0}}};

   function automatic logic [RW-1:0] round_mag(input logic [MW-1:0] mag, input logic rnd);
      logic [RW-1:0] inc;
      inc = (ROUND != 0) ? {{(RW-1){1'b0}}, rnd} : '0;
      return {1'b0, mag} + inc;
   endfunction

   // Returns {sat, magnitude}; landing exactly on 1.0 after rounding is not a saturation.
   function automatic logic [RW:0] sat_mag(input logic [RW-1:0] mag, input logic big);
      if (big || (mag > ONE)) return {1'b1, ONE};
      return {1'b0, mag};
   endfunction

   logic          vld_p0_q, vld_p1_q, vld_p2_q;
   logic          stall, adv;
   logic [7:0]    exp_d;
   logic [22:0]   frc_d;
   logic          sgn_p0_q, nan_p0_q, inf_p0_q, gt1_p0_q, unit_p0_q, nz_p0_q;
   logic [7:0]    exp_p0_q;
   logic [23:0]   man_p0_q;
   int            sh;
   logic [23:0]   tmp_a;
   logic [MW-1:0] mag_d;
   logic          rnd_d, big_d;
   logic          sgn_p1_q, nan_p1_q, big_p1_q, unit_p1_q, nz_p1_q, rnd_p1_q;
   logic [MW-1:0] mag_p1_q;
   logic [RW-1:0] mrnd, mfin, res_d;
   logic          sat_d, zero_d;
   logic [4:0]    flg_d;
   logic [RW-1:0] res_p2_q;
   logic [4:0]    flg_p2_q;

   assign stall        = vld_p2_q & ~bus.out_ready;
   assign adv          = ~stall;
   assign bus.in_ready = ~stall;
   assign exp_d        = bus.in_data[30:23];
   assign frc_d        = bus.in_data[22:0];

   // S1: decode
   always_ff @(posedge clk) begin
      if (adv) begin
         sgn_p0_q  <= bus.in_data[31];
         exp_p0_q  <= exp_d;
         man_p0_q  <= {1'b1, frc_d};
         nan_p0_q  <= (exp_d == 8'hFF) && (frc_d != '0);
         inf_p0_q  <= (exp_d == 8'hFF) && (frc_d == '0);
         gt1_p0_q  <= (exp_d == 8'd127) && (frc_d != '0);
         unit_p0_q <= (exp_d == 8'd127) && (frc_d == '0);
         nz_p0_q   <= (exp_d != 8'hFF) && ((exp_d != 8'd0) || (frc_d != '0));
      end
   end

   // S2: align; sh is the right-shift distance that puts the binary point at FRAC_WIDTH
   always_comb begin
      sh    = 150 - FRAC_WIDTH - int'(exp_p0_q);
      tmp_a = '0;
      mag_d = '0;
      rnd_d = 1'b0;
      big_d = inf_p0_q | gt1_p0_q;
      if (!nan_p0_q && !inf_p0_q && (exp_p0_q != 8'd0)) begin
         if ((sh <= 0) || (exp_p0_q >= 8'd128)) begin
            big_d = 1'b1;
         end else if (sh <= 24) begin
            tmp_a = man_p0_q >> (sh - 1);
            rnd_d = tmp_a[0];
            mag_d = MW'(tmp_a >> 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         sgn_p1_q  <= sgn_p0_q;
         nan_p1_q  <= nan_p0_q;
         big_p1_q  <= big_d;
         unit_p1_q <= unit_p0_q;
         nz_p1_q   <= nz_p0_q;
         rnd_p1_q  <= rnd_d;
         mag_p1_q  <= mag_d;
      end
   end

   // S3: round, saturate, negate, classify
   always_comb begin
      mrnd            = round_mag(mag_p1_q, rnd_p1_q);
      {sat_d, mfin}   = sat_mag(mrnd, big_p1_q);
      if (nan_p1_q) begin
         sat_d = 1'b0;
         mfin  = '0;
      end
      res_d  = sgn_p1_q ? (~mfin + 1'b1) : mfin;
      zero_d = (res_d == '0);
      flg_d  = {nz_p1_q & zero_d, nan_p1_q, sat_d, unit_p1_q, zero_d};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p0_q <= 1'b0;
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         res_p2_q <= '0;
         flg_p2_q <= '0;
      end else if (adv) begin
         vld_p0_q <= bus.in_valid;
         vld_p1_q <= vld_p0_q;
         vld_p2_q <= vld_p1_q;
         res_p2_q <= res_d;
         flg_p2_q <= flg_d;
      end
   end

   assign bus.out_valid  = vld_p2_q;
   assign bus.out_result = res_p2_q;
   assign bus.out_flags  = flg_p2_q;
endmodule

// File: tb/tb_float_unpacker_pipe.sv
// Directed bench for float_unpacker_pipe: three instances (22-bit truncate, 22-bit round, 14-bit truncate)
// share one stimulus stream; expected words are {flags, result} written out by hand.
module tb_float_unpacker_pipe;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   float_unpacker_pipe_if #(.FRAC_WIDTH(22)) a ();
   float_unpacker_pipe_if #(.FRAC_WIDTH(22)) b ();
   float_unpacker_pipe_if #(.FRAC_WIDTH(14)) c ();

   float_unpacker_pipe #(.FRAC_WIDTH(22), .ROUND(0)) u_a (.clk(clk), .reset(reset), .bus(a.slave));
   float_unpacker_pipe #(.FRAC_WIDTH(22), .ROUND(1)) u_b (.clk(clk), .reset(reset), .bus(b.slave));
   float_unpacker_pipe #(.FRAC_WIDTH(14), .ROUND(0)) u_c (.clk(clk), .reset(reset), .bus(c.slave));

   int n_chk = 0;
   int n_bad = 0;
   logic [31:0] qa[$];
   logic [31:0] qb[$];
   logic [31:0] qc[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] d);
      a.in_valid = v; b.in_valid = v; c.in_valid = v;
      a.in_data  = d; b.in_data  = d; c.in_data  = d;
   endtask

   task automatic set_rdy(input logic r);
      a.out_ready = r; b.out_ready = r; c.out_ready = r;
   endtask

   // Presents one value and returns just after the edge that accepted it.
   task automatic send(input logic [31:0] d, input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] xc);
      drive(1'b1, d);
      for (int g = 0; g < 40; g++) begin
         @(negedge clk);
         if (a.in_ready) begin
            qa.push_back(xa); qb.push_back(xb); qc.push_back(xc);
            @(posedge clk); #1;
            drive(1'b0, 32'h0);
            return;
         end
      end
      chk("send_timeout", {31'b0, a.in_ready}, 32'd1);
      drive(1'b0, 32'h0);
   endtask

   task automatic drain();
      for (int g = 0; g < 40; g++) begin
         if (qa.size() == 0 && qb.size() == 0 && qc.size() == 0) break;
         @(posedge clk); #1;
      end
      chk("drain_a", qa.size(), 0);
      chk("drain_b", qb.size(), 0);
      chk("drain_c", qc.size(), 0);
   endtask

   always @(negedge clk) begin
      if (a.out_valid && a.out_ready) begin
         if (qa.size() == 0) chk("a_unexpected", {31'b0, a.out_valid}, 32'd0);
         else chk("a_out", {3'b0, a.out_flags, a.out_result}, qa.pop_front());
      end
      if (b.out_valid && b.out_ready) begin
         if (qb.size() == 0) chk("b_unexpected", {31'b0, b.out_valid}, 32'd0);
         else chk("b_out", {3'b0, b.out_flags, b.out_result}, qb.pop_front());
      end
      if (c.out_valid && c.out_ready) begin
         if (qc.size() == 0) chk("c_unexpected", {31'b0, c.out_valid}, 32'd0);
         else chk("c_out", {11'b0, c.out_flags, c.out_result}, qc.pop_front());
      end
   end

   initial begin
      reset = 1'b1;
      drive(1'b0, 32'h0);
      set_rdy(1'b1);
      @(posedge clk); @(posedge clk); #1;
      chk("rst_vld", {31'b0, a.out_valid}, 32'd0);
      chk("rst_res", {8'b0, a.out_result}, 32'd0);
      chk("rst_flg", {27'b0, a.out_flags}, 32'd0);
      chk("rst_rdy", {31'b0, a.in_ready}, 32'd1);
      chk("rst_res14", {16'b0, c.out_result}, 32'd0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;

      // back-to-back basic stream
      send(32'h3F800000, 32'h02400000, 32'h02400000, 32'h00024000);
      send(32'hBF800000, 32'h02C00000, 32'h02C00000, 32'h0002C000);
      send(32'h3F000000, 32'h00200000, 32'h00200000, 32'h00002000);
      send(32'h3F47AE14, 32'h0031EB85, 32'h0031EB85, 32'h000031EB);
      send(32'h350637BD, 32'h00000002, 32'h00000002, 32'h00110000);
      send(32'h00000000, 32'h01000000, 32'h01000000, 32'h00010000);
      // saturation and special values
      send(32'h3FC00000, 32'h04400000, 32'h04400000, 32'h00044000);
      send(32'hC0000000, 32'h04C00000, 32'h04C00000, 32'h0004C000);
      send(32'h7F800000, 32'h04400000, 32'h04400000, 32'h00044000);
      send(32'hFF800000, 32'h04C00000, 32'h04C00000, 32'h0004C000);
      send(32'h7FC00000, 32'h09000000, 32'h09000000, 32'h00090000);
      send(32'h3F800001, 32'h04400000, 32'h04400000, 32'h00044000);
      // rounding, underflow, denormal, negative zero
      send(32'h3F000002, 32'h00200000, 32'h00200001, 32'h00002000);
      send(32'hBF000002, 32'h00E00000, 32'h00DFFFFF, 32'h0000E000);
      send(32'h3F7FFFFF, 32'h003FFFFF, 32'h00400000, 32'h00003FFF);
      send(32'h34000000, 32'h11000000, 32'h00000001, 32'h00110000);
      send(32'h33800000, 32'h11000000, 32'h11000000, 32'h00110000);
      send(32'h00000001, 32'h11000000, 32'h11000000, 32'h00110000);
      send(32'h80000000, 32'h01000000, 32'h01000000, 32'h00010000);
      send(32'hBF000000, 32'h00E00000, 32'h00E00000, 32'h0000E000);
      drain();

      // backpressure: hold out_ready low for 5 cycles once the first result shows
      fork
         begin
            send(32'h3F000000, 32'h00200000, 32'h00200000, 32'h00002000);
            send(32'hBF000000, 32'h00E00000, 32'h00E00000, 32'h0000E000);
            send(32'h3F800000, 32'h02400000, 32'h02400000, 32'h00024000);
            send(32'h3FC00000, 32'h04400000, 32'h04400000, 32'h00044000);
         end
         begin
            for (int g = 0; g < 20 && !a.out_valid; g++) begin
               @(posedge clk); #1;
            end
            chk("bp_seen", {31'b0, a.out_valid}, 32'd1);
            set_rdy(1'b0);
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               chk("bp_inrdy", {31'b0, a.in_ready}, 32'd0);
               chk("bp_hold_a", {3'b0, a.out_flags, a.out_result}, 32'h00200000);
               chk("bp_hold_c", {11'b0, c.out_flags, c.out_result}, 32'h00002000);
               @(posedge clk); #1;
            end
            set_rdy(1'b1);
         end
      join
      drain();

      // reset with three values in flight
      send(32'h3F000000, 32'h00200000, 32'h00200000, 32'h00002000);
      send(32'hBF000000, 32'h00E00000, 32'h00E00000, 32'h0000E000);
      send(32'h3F800000, 32'h02400000, 32'h02400000, 32'h00024000);
      chk("rst_pre_vld", {31'b0, a.out_valid}, 32'd1);
      #2;
      reset = 1'b1;
      qa.delete(); qb.delete(); qc.delete();
      #1;
      chk("rst_async_a", {31'b0, a.out_valid}, 32'd0);
      chk("rst_async_c", {31'b0, c.out_valid}, 32'd0);
      @(posedge clk); @(posedge clk); #2;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst_idle", {31'b0, a.out_valid}, 32'd0);
      end
      @(posedge clk); #1;
      send(32'h3F47AE14, 32'h0031EB85, 32'h0031EB85, 32'h000031EB);
      chk("lat0", {31'b0, a.out_valid}, 32'd0);
      @(posedge clk); #1;
      chk("lat1", {31'b0, a.out_valid}, 32'd0);
      @(posedge clk); #1;
      chk("lat2", {31'b0, a.out_valid}, 32'd1);
      chk("lat_res", {3'b0, a.out_flags, a.out_result}, 32'h0031EB85);
      drain();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
